fb_mem_arbiter: RTL and testbench
=================================

# fb_mem_arbiter

Arbitrates one external 16-bit asynchronous SRAM port between the CPU data-memory path and the VGA framebuffer fill path (`vga_re`/`vga_addr`/`vga_data`/`vga_success`). It grants one requester at a time, sequences a fixed-length SRAM cycle and returns read data with a multi-cycle acknowledge. It sits between the CPU memory interface, `vga_control` and the SRAM pins.

## Interface
- `ADDR_W`, 23: word address width.
- `DATA_W`, 16: data width.
- `WAIT_CYCLES`, 2: SRAM access cycles. Legal values are 2 to 15.
- `ACK_HOLD`, 3: cycles the ack/success output stays high. Legal values are 1 to 7.

Ports:
- `clk`  in  1  system clock; every register uses the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `cpu_req`  in  1  CPU request.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  CPU word address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_be`  in  2  byte enables.
- `cpu_rdata`  out  DATA_W  CPU read data, registered.
- `cpu_ack`  out  1  CPU acknowledge.
- `vga_re`  in  1  VGA read request. The VGA path is read-only.
- `vga_addr`  in  ADDR_W  VGA word address.
- `vga_data`  out  DATA_W  VGA read data, registered.
- `vga_success`  out  1  VGA acknowledge.
- `mem_ce_n`, `mem_oe_n`, `mem_we_n`  out  1 each  SRAM strobes, active low.
- `mem_be_n`  out  2  SRAM byte enables, active low.
- `mem_addr`  out  ADDR_W  SRAM address.
- `mem_dq_o`  out  DATA_W  write data.
- `mem_dq_oe`  out  1  data-bus drive enable.
- `mem_dq_i`  in  DATA_W  read data.

## Operation
- States: IDLE, ACCESS, ACK.
- **IDLE**
  - If any request is high, latch the winner's identity, we, addr, wdata and be (VGA: we=0, be=2'b11), clear the wait counter and go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS**
  - `mem_ce_n`=0, `mem_addr` and `mem_be_n` come from the latch.
  - Read: `mem_oe_n`=0, `mem_dq_oe`=0.
  - Write: `mem_dq_oe`=1; `mem_we_n`=0 in ACCESS cycles 1..WAIT_CYCLES-1 and 1 in the last cycle (data hold).
  - The counter counts 0..WAIT_CYCLES-1. On the last cycle, a read captures `mem_dq_i` into the granted requester's rdata register, then the block goes to ACK.
- **ACK**
  - All strobes inactive.
  - The granted requester's ack is high for exactly ACK_HOLD cycles, then the block returns to IDLE.
  - Write data is not returned; `cpu_rdata` is unchanged after a write.
- Each rdata register holds its value until that requester's next read completes.
- Request inputs are sampled only in IDLE:
  - Address or request changes during ACCESS/ACK do not affect the access in flight.
  - A request dropped mid-access still completes and is still acked.
- Simultaneous requests in IDLE: CPU wins (see Configuration).
- A requester that keeps its request high is re-granted in the IDLE cycle following its ACK.

## Timing
- All outputs are registered.
- Reset values: `mem_ce_n`=`mem_oe_n`=`mem_we_n`=1, `mem_be_n`=2'b11, `mem_dq_oe`=0, `mem_addr`=0, `mem_dq_o`=0, `cpu_ack`=`vga_success`=0, `cpu_rdata`=`vga_data`=0, state IDLE.
- Reset assertion forces these values immediately, including mid-ACCESS. The SRAM cycle is aborted and no ack is issued.
- Request high in IDLE cycle t:
  - ACCESS occupies cycles t+1..t+WAIT_CYCLES.
  - Read data is captured at the end of cycle t+WAIT_CYCLES.
  - Ack is high in cycles t+WAIT_CYCLES+1..t+WAIT_CYCLES+ACK_HOLD, with rdata already valid in the first ack cycle.
  - IDLE is cycle t+WAIT_CYCLES+ACK_HOLD+1.
- Back-to-back period: WAIT_CYCLES+ACK_HOLD+1 cycles. Defaults give 6 cycles.
- `cpu_ack` and `vga_success` are never high in the same cycle.

## Configuration
- `FB_ARB_ROUND_ROBIN_EN`
  - Defined: a 1-bit last-grant register (reset: VGA) breaks ties. When both requests are high in IDLE, the requester not granted last wins. Single requests are granted as usual.
  - Undefined: fixed CPU priority. VGA is granted only when `cpu_req`=0 in IDLE.

## Test plan
- **VGA read:** `vga_re`=1, `vga_addr`=0x000010, `mem_dq_i`=16'hA5C3, defaults → `mem_ce_n`/`mem_oe_n` low for 2 cycles with `mem_addr`=0x10; `vga_success` high 3 cycles with `vga_data`=16'hA5C3; `mem_dq_oe` stays 0.
- **CPU write:** `cpu_we`=1, `cpu_addr`=0x7FFFFF, `cpu_wdata`=16'h1234, `cpu_be`=2'b01 → `mem_be_n`=2'b10, `mem_dq_o`=16'h1234, `mem_we_n` low only in the first ACCESS cycle, `cpu_ack` high 3 cycles, `cpu_rdata` unchanged.
- **Contention:** `cpu_req` and `vga_re` both held high.
  - Without the macro: CPU is granted every 6 cycles and `vga_success` never rises.
  - With the macro: grants alternate CPU, VGA, CPU.
- **Request drop:** `vga_addr` changed and `vga_re` dropped during the first ACCESS cycle → the original address stays on `mem_addr` and `vga_success` is still asserted 3 cycles.
- **Reset mid-access:** `rst`=0 in the second ACCESS cycle → all strobes inactive in the same cycle, no ack; after release, a new request completes normally.
- **Parameter corner:** WAIT_CYCLES=15, ACK_HOLD=1 → 15 ACCESS cycles, a 1-cycle ack, and a 17-cycle back-to-back period.

Source files
------------

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter
//   Shares one external 16-bit asynchronous SRAM port between the CPU data path
//   and the VGA framebuffer fill path. One requester is granted at a time. Each
//   grant runs a fixed WAIT_CYCLES SRAM access, then holds the requester's
//   acknowledge for ACK_HOLD cycles, then returns to IDLE.
//
// Optional feature (compile-time macro FB_ARB_ROUND_ROBIN_EN):
//   defined   : simultaneous requests are resolved by a last-grant bit
//               (after reset, CPU wins the first tie).
//   undefined : fixed CPU priority.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata/be CPU request side (be = byte enables, active high)
//   cpu_rdata, cpu_ack       registered CPU read data and acknowledge
//   vga_re, vga_addr         VGA read request (the VGA path never writes)
//   vga_data, vga_success    registered VGA read data and acknowledge
//   mem_ce_n/oe_n/we_n       SRAM strobes, active low
//   mem_be_n                 SRAM byte enables, active low
//   mem_addr, mem_dq_o       SRAM address and write data
//   mem_dq_oe                data-bus drive enable (high only during writes)
//   mem_dq_i                 SRAM read data
//
// Every output comes straight from a flop. The combinational process computes
// the value each output takes in the next cycle.
module fb_mem_arbiter #(
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2,   // legal 2..15
  parameter int ACK_HOLD    = 3    // legal 1..7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [1:0]        cpu_be,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              vga_re,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_success,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic [1:0]        mem_be_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dq_o,
  output logic              mem_dq_oe,
  input  logic [DATA_W-1:0] mem_dq_i
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [2:0] ACK_LAST  = 3'(ACK_HOLD - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;          // ACCESS cycle index
  logic [2:0]          ack_cnt_reg, ack_cnt_next;  // ACK cycle index
  logic                grant_vga_reg, grant_vga_next;
  logic                we_lat_reg, we_lat_next;

  logic                ce_n_reg, ce_n_next;
  logic                oe_n_reg, oe_n_next;
  logic                we_n_reg, we_n_next;
  logic [1:0]          be_n_reg, be_n_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   dq_o_reg, dq_o_next;
  logic                dq_oe_reg, dq_oe_next;
  logic [DATA_W-1:0]   cpu_rdata_reg, cpu_rdata_next;
  logic [DATA_W-1:0]   vga_data_reg, vga_data_next;
  logic                cpu_ack_reg, cpu_ack_next;
  logic                vga_success_reg, vga_success_next;

  logic                pick_vga;
  logic                sel_we;

`ifdef FB_ARB_ROUND_ROBIN_EN
  // 1 = VGA was granted last; reset value VGA hands the first tie to the CPU.
  logic                last_grant_reg, last_grant_next;
`endif

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    ack_cnt_next     = ack_cnt_reg;
    grant_vga_next   = grant_vga_reg;
    we_lat_next      = we_lat_reg;
    ce_n_next        = ce_n_reg;
    oe_n_next        = oe_n_reg;
    we_n_next        = we_n_reg;
    be_n_next        = be_n_reg;
    addr_next        = addr_reg;
    dq_o_next        = dq_o_reg;
    dq_oe_next       = dq_oe_reg;
    cpu_rdata_next   = cpu_rdata_reg;
    vga_data_next    = vga_data_reg;
    cpu_ack_next     = cpu_ack_reg;
    vga_success_next = vga_success_reg;
    pick_vga         = 1'b0;
    sel_we           = 1'b0;
`ifdef FB_ARB_ROUND_ROBIN_EN
    last_grant_next  = last_grant_reg;
    pick_vga         = vga_re && (!cpu_req || !last_grant_reg);
`else
    pick_vga         = vga_re && !cpu_req;
`endif

    case (state_reg)
      IDLE: begin
        if (cpu_req || vga_re) begin
          sel_we         = pick_vga ? 1'b0 : cpu_we;
          state_next     = ACCESS;
          cnt_next       = 4'd0;
          grant_vga_next = pick_vga;
          we_lat_next    = sel_we;
`ifdef FB_ARB_ROUND_ROBIN_EN
          last_grant_next = pick_vga;
`endif
          // The output registers double as the request latch, so the access
          // is immune to input changes until it finishes.
          addr_next      = pick_vga ? vga_addr : cpu_addr;
          be_n_next      = pick_vga ? 2'b00 : ~cpu_be;
          if (!pick_vga) dq_o_next = cpu_wdata;
          ce_n_next      = 1'b0;
          oe_n_next      = sel_we;
          we_n_next      = ~sel_we;
          dq_oe_next     = sel_we;
        end
      end

      ACCESS: begin
        if (cnt_reg == WAIT_LAST) begin
          state_next   = ACK;
          ack_cnt_next = 3'd0;
          ce_n_next    = 1'b1;
          oe_n_next    = 1'b1;
          we_n_next    = 1'b1;
          be_n_next    = 2'b11;
          dq_oe_next   = 1'b0;
          if (!we_lat_reg) begin
            if (grant_vga_reg) vga_data_next  = mem_dq_i;
            else               cpu_rdata_next = mem_dq_i;
          end
          if (grant_vga_reg) vga_success_next = 1'b1;
          else               cpu_ack_next     = 1'b1;
        end else begin
          cnt_next = cnt_reg + 4'd1;
          // Release WE one cycle early so write data is held past the edge.
          if (cnt_reg + 4'd1 == WAIT_LAST) we_n_next = 1'b1;
        end
      end

      ACK: begin
        if (ack_cnt_reg == ACK_LAST) begin
          state_next       = IDLE;
          cpu_ack_next     = 1'b0;
          vga_success_next = 1'b0;
        end else begin
          ack_cnt_next = ack_cnt_reg + 3'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      ack_cnt_reg     <= '0;
      grant_vga_reg   <= 1'b0;
      we_lat_reg      <= 1'b0;
      ce_n_reg        <= 1'b1;
      oe_n_reg        <= 1'b1;
      we_n_reg        <= 1'b1;
      be_n_reg        <= 2'b11;
      addr_reg        <= '0;
      dq_o_reg        <= '0;
      dq_oe_reg       <= 1'b0;
      cpu_rdata_reg   <= '0;
      vga_data_reg    <= '0;
      cpu_ack_reg     <= 1'b0;
      vga_success_reg <= 1'b0;
`ifdef FB_ARB_ROUND_ROBIN_EN
      last_grant_reg  <= 1'b1;
`endif
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      ack_cnt_reg     <= ack_cnt_next;
      grant_vga_reg   <= grant_vga_next;
      we_lat_reg      <= we_lat_next;
      ce_n_reg        <= ce_n_next;
      oe_n_reg        <= oe_n_next;
      we_n_reg        <= we_n_next;
      be_n_reg        <= be_n_next;
      addr_reg        <= addr_next;
      dq_o_reg        <= dq_o_next;
      dq_oe_reg       <= dq_oe_next;
      cpu_rdata_reg   <= cpu_rdata_next;
      vga_data_reg    <= vga_data_next;
      cpu_ack_reg     <= cpu_ack_next;
      vga_success_reg <= vga_success_next;
`ifdef FB_ARB_ROUND_ROBIN_EN
      last_grant_reg  <= last_grant_next;
`endif
    end
  end

  assign mem_ce_n    = ce_n_reg;
  assign mem_oe_n    = oe_n_reg;
  assign mem_we_n    = we_n_reg;
  assign mem_be_n    = be_n_reg;
  assign mem_addr    = addr_reg;
  assign mem_dq_o    = dq_o_reg;
  assign mem_dq_oe   = dq_oe_reg;
  assign cpu_rdata   = cpu_rdata_reg;
  assign vga_data    = vga_data_reg;
  assign cpu_ack     = cpu_ack_reg;
  assign vga_success = vga_success_reg;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed testbench for fb_mem_arbiter: a default-parameter instance (u_dut)
// and a WAIT_CYCLES=15 / ACK_HOLD=1 instance (u_corner) sharing the stimulus.
module tb_fb_mem_arbiter;
  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we, vga_re;
  logic [ADDR_W-1:0] cpu_addr, vga_addr;
  logic [DATA_W-1:0] cpu_wdata, mem_dq_i;
  logic [1:0]        cpu_be;

  logic [DATA_W-1:0] cpu_rdata, vga_data, mem_dq_o;
  logic              cpu_ack, vga_success, mem_ce_n, mem_oe_n, mem_we_n, mem_dq_oe;
  logic [1:0]        mem_be_n;
  logic [ADDR_W-1:0] mem_addr;

  logic [DATA_W-1:0] c_cpu_rdata, c_vga_data, c_mem_dq_o;
  logic              c_cpu_ack, c_vga_success, c_mem_ce_n, c_mem_oe_n, c_mem_we_n, c_mem_dq_oe;
  logic [1:0]        c_mem_be_n;
  logic [ADDR_W-1:0] c_mem_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_mem_arbiter u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vga_re(vga_re), .vga_addr(vga_addr), .vga_data(vga_data), .vga_success(vga_success),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .mem_be_n(mem_be_n),
    .mem_addr(mem_addr), .mem_dq_o(mem_dq_o), .mem_dq_oe(mem_dq_oe), .mem_dq_i(mem_dq_i)
  );

  fb_mem_arbiter #(.WAIT_CYCLES(15), .ACK_HOLD(1)) u_corner (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_rdata(c_cpu_rdata), .cpu_ack(c_cpu_ack),
    .vga_re(vga_re), .vga_addr(vga_addr), .vga_data(c_vga_data), .vga_success(c_vga_success),
    .mem_ce_n(c_mem_ce_n), .mem_oe_n(c_mem_oe_n), .mem_we_n(c_mem_we_n), .mem_be_n(c_mem_be_n),
    .mem_addr(c_mem_addr), .mem_dq_o(c_mem_dq_o), .mem_dq_oe(c_mem_dq_oe), .mem_dq_i(mem_dq_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller has raised the request during an IDLE cycle. Walks ACCESS (2),
  // ACK (3) and the following IDLE cycle, checking the pins every cycle.
  // Requests are dropped after the grant; scramble also changes the addresses.
  task automatic do_access(input string name, input bit is_vga, input bit we,
                           input logic [ADDR_W-1:0] addr, input logic [1:0] be_n,
                           input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata_exp,
                           input bit scramble);
    tick();
    cpu_req = 1'b0;
    vga_re  = 1'b0;
    if (scramble) begin
      vga_addr = 23'h000055;
      cpu_addr = 23'h000066;
    end
    for (int i = 1; i <= 2; i++) begin
      if (i > 1) tick();
      check({name, " ce_n"},  mem_ce_n, 0);
      check({name, " oe_n"},  mem_oe_n, we ? 1 : 0);
      check({name, " we_n"},  mem_we_n, (we && i == 1) ? 0 : 1);
      check({name, " dq_oe"}, mem_dq_oe, we ? 1 : 0);
      check({name, " addr"},  mem_addr, addr);
      check({name, " be_n"},  mem_be_n, be_n);
      if (we) check({name, " dq_o"}, mem_dq_o, wdata);
      check({name, " no ack in access"}, {cpu_ack, vga_success}, 0);
    end
    for (int j = 1; j <= 3; j++) begin
      tick();
      check({name, " cpu_ack"},     cpu_ack, is_vga ? 0 : 1);
      check({name, " vga_success"}, vga_success, is_vga ? 1 : 0);
      check({name, " ack strobes"}, {mem_ce_n, mem_oe_n, mem_we_n, mem_dq_oe}, 4'b1110);
      if (is_vga) check({name, " vga_data"}, vga_data, rdata_exp);
      else        check({name, " cpu_rdata"}, cpu_rdata, rdata_exp);
    end
    tick();
    check({name, " idle acks"}, {cpu_ack, vga_success}, 0);
    check({name, " idle ce_n"}, mem_ce_n, 1);
    $display("txn %s: vga=%0d we=%0d addr=%06h", name, is_vga, we, addr);
  endtask

  initial begin
    bit ack_ph, vga_turn;
    int phase, per;

    rst = 1'b0; cpu_req = 0; cpu_we = 0; vga_re = 0;
    cpu_addr = '0; vga_addr = '0; cpu_wdata = '0; cpu_be = 2'b00; mem_dq_i = '0;
    tick();
    tick();
    check("reset strobes", {mem_ce_n, mem_oe_n, mem_we_n, mem_dq_oe}, 4'b1110);
    check("reset be_n", mem_be_n, 2'b11);
    check("reset addr", mem_addr, 0);
    check("reset dq_o", mem_dq_o, 0);
    check("reset acks", {cpu_ack, vga_success}, 0);
    check("reset cpu_rdata", cpu_rdata, 0);
    check("reset vga_data", vga_data, 0);
    rst = 1'b1;
    tick();

    // VGA read
    vga_re = 1; vga_addr = 23'h000010; mem_dq_i = 16'hA5C3;
    do_access("vga_read", 1, 0, 23'h000010, 2'b00, 16'h0, 16'hA5C3, 0);

    // CPU read sets a known cpu_rdata; vga_data must keep its value
    cpu_req = 1; cpu_we = 0; cpu_addr = 23'h000100; cpu_be = 2'b11; mem_dq_i = 16'hBEEF;
    do_access("cpu_read", 0, 0, 23'h000100, 2'b00, 16'h0, 16'hBEEF, 0);
    check("vga_data held", vga_data, 16'hA5C3);

    // CPU write: bus data differs, cpu_rdata must not change
    cpu_req = 1; cpu_we = 1; cpu_addr = 23'h7FFFFF; cpu_wdata = 16'h1234; cpu_be = 2'b01;
    mem_dq_i = 16'h5555;
    do_access("cpu_write", 0, 1, 23'h7FFFFF, 2'b10, 16'h1234, 16'hBEEF, 0);
    cpu_we = 0;

    // Request dropped and address changed during the first ACCESS cycle
    vga_re = 1; vga_addr = 23'h000020; mem_dq_i = 16'h7E7E;
    do_access("vga_drop", 1, 0, 23'h000020, 2'b00, 16'h0, 16'h7E7E, 1);

    // Reset in the second ACCESS cycle
    cpu_req = 1; cpu_we = 0; cpu_addr = 23'h000044; cpu_be = 2'b11; mem_dq_i = 16'h1111;
    tick();
    cpu_req = 0;
    tick();
    check("pre-reset ce_n", mem_ce_n, 0);
    rst = 1'b0;
    #1;
    check("midrst strobes", {mem_ce_n, mem_oe_n, mem_we_n, mem_dq_oe}, 4'b1110);
    check("midrst be_n", mem_be_n, 2'b11);
    check("midrst addr", mem_addr, 0);
    tick();
    check("midrst no ack", {cpu_ack, vga_success}, 0);
    check("midrst cpu_rdata", cpu_rdata, 0);
    rst = 1'b1;
    vga_re = 1; vga_addr = 23'h000033; mem_dq_i = 16'h2222;
    do_access("after_reset", 1, 0, 23'h000033, 2'b00, 16'h0, 16'h2222, 0);

    // Contention: both requests held for three periods
    rst = 1'b0;
    tick();
    rst = 1'b1;
    cpu_req = 1; vga_re = 1; cpu_we = 0; cpu_addr = 23'h000001; vga_addr = 23'h000002;
    for (int k = 1; k <= 18; k++) begin
      tick();
      phase  = (k - 1) % 6;
      per    = (k - 1) / 6;
      ack_ph = (phase >= 2 && phase <= 4);
`ifdef FB_ARB_ROUND_ROBIN_EN
      vga_turn = (per % 2 == 1);
`else
      vga_turn = 1'b0;
`endif
      check("contend cpu_ack", cpu_ack, (ack_ph && !vga_turn) ? 1 : 0);
      check("contend vga_success", vga_success, (ack_ph && vga_turn) ? 1 : 0);
      if (phase == 0) check("contend addr", mem_addr, vga_turn ? 23'h2 : 23'h1);
    end
    cpu_req = 0; vga_re = 0;
    $display("txn contention: 3 periods");

    // Parameter corner on u_corner: 15 ACCESS cycles, 1-cycle ack, period 17
    rst = 1'b0;
    tick();
    rst = 1'b1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 23'h000003; cpu_be = 2'b11; mem_dq_i = 16'h0F0F;
    for (int k = 1; k <= 34; k++) begin
      tick();
      phase = (k - 1) % 17;
      check("corner ce_n", c_mem_ce_n, (phase < 15) ? 0 : 1);
      check("corner cpu_ack", c_cpu_ack, (phase == 15) ? 1 : 0);
      if (phase == 15) check("corner cpu_rdata", c_cpu_rdata, 16'h0F0F);
    end
    cpu_req = 0;
    $display("txn corner: 2 periods of 17");

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
